// File: rtl/button_event_decoder.sv
// Turns debounced button level/edge pulses into short, long and double-click events.
// Define HOLD_REPEAT_EN to add the auto-repeat tick while a long press is held.
module button_event_decoder #(
    parameter int LONG_CYC   = 50_000_000,
    parameter int DBL_CYC    = 15_000_000,
    parameter int REPEAT_CYC = 10_000_000,
    parameter int CNT_W      = 26
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       pb_state,
    input  logic       pb_down,
    input  logic       pb_up,
    output logic       short_press,
    output logic       long_press,
    output logic       double_click,
    output logic       repeat_tick,
    output logic [7:0] event_cnt
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        PRESS1 = 3'd1,
        WAIT2  = 3'd2,
        PRESS2 = 3'd3,
        LONG   = 3'd4
    } state_t;

    localparam logic [CNT_W-1:0] LONG_LAST = CNT_W'(LONG_CYC - 1);
    localparam logic [CNT_W-1:0] DBL_LAST  = CNT_W'(DBL_CYC - 1);

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             short_q, short_d;
    logic             long_q, long_d;
    logic             dbl_q, dbl_d;
    logic [7:0]       event_cnt_q, event_cnt_d;
    logic             press, release_ev;

    // Simultaneous down/up is a glitch and is ignored; a low level counts as release only without pb_up.
    assign press      = pb_down & ~pb_up;
    assign release_ev = pb_up ? ~pb_down : ~pb_state;

    always_comb begin
        state_d = state_q;
        short_d = 1'b0;
        long_d  = 1'b0;
        dbl_d   = 1'b0;
        case (state_q)
            IDLE: begin
                if (press) state_d = PRESS1;
            end
            PRESS1: begin
                if (release_ev) begin
                    state_d = WAIT2;
                end else if (cnt_q == LONG_LAST) begin
                    state_d = LONG;
                    long_d  = 1'b1;
                end
            end
            WAIT2: begin
                if (press) begin
                    state_d = PRESS2;
                end else if (cnt_q == DBL_LAST) begin
                    state_d = IDLE;
                    short_d = 1'b1;
                end
            end
            PRESS2: begin
                if (release_ev) begin
                    state_d = IDLE;
                    dbl_d   = 1'b1;
                end
            end
            LONG: begin
                if (release_ev) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase

        if (state_d != state_q) begin
            cnt_d = '0;
        end else if (state_q == PRESS1 || state_q == WAIT2 || state_q == LONG) begin
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = '0;
        end

        event_cnt_d = event_cnt_q + {7'd0, short_d | long_d | dbl_d};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            short_q     <= 1'b0;
            long_q      <= 1'b0;
            dbl_q       <= 1'b0;
            event_cnt_q <= 8'd0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            short_q     <= short_d;
            long_q      <= long_d;
            dbl_q       <= dbl_d;
            event_cnt_q <= event_cnt_d;
        end
    end

`ifdef HOLD_REPEAT_EN
    localparam logic [CNT_W-1:0] REP_LAST = CNT_W'(REPEAT_CYC - 1);

    logic [CNT_W-1:0] rep_cnt_q, rep_cnt_d;
    logic             rep_tick_q, rep_tick_d;

    // Separate phase counter so ticks stay periodic while the main timer keeps running in LONG.
    always_comb begin
        rep_cnt_d  = '0;
        rep_tick_d = 1'b0;
        if (state_q == LONG && state_d == LONG) begin
            if (rep_cnt_q == REP_LAST) begin
                rep_tick_d = 1'b1;
            end else begin
                rep_cnt_d = rep_cnt_q + CNT_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rep_cnt_q  <= '0;
            rep_tick_q <= 1'b0;
        end else begin
            rep_cnt_q  <= rep_cnt_d;
            rep_tick_q <= rep_tick_d;
        end
    end

    assign repeat_tick = rep_tick_q;
`else
    assign repeat_tick = 1'b0;
`endif

    assign short_press  = short_q;
    assign long_press   = long_q;
    assign double_click = dbl_q;
    assign event_cnt    = event_cnt_q;

endmodule

// File: tb/tb_button_event_decoder.sv
// Directed bench for button_event_decoder with LONG_CYC=10, DBL_CYC=5, REPEAT_CYC=4.
module tb_button_event_decoder;

`ifdef HOLD_REPEAT_EN
    localparam bit REP_EN = 1'b1;
`else
    localparam bit REP_EN = 1'b0;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       pb_state = 1'b0;
    logic       pb_down = 1'b0;
    logic       pb_up = 1'b0;
    logic       short_press, long_press, double_click, repeat_tick;
    logic [7:0] event_cnt;

    int total = 0;
    int bad = 0;

    button_event_decoder #(
        .LONG_CYC(10),
        .DBL_CYC(5),
        .REPEAT_CYC(4),
        .CNT_W(8)
    ) dut (
        .clk(clk),
        .rst(rst),
        .pb_state(pb_state),
        .pb_down(pb_down),
        .pb_up(pb_up),
        .short_press(short_press),
        .long_press(long_press),
        .double_click(double_click),
        .repeat_tick(repeat_tick),
        .event_cnt(event_cnt)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       st;
        logic       dn;
        logic       up;
        logic       rs;
        logic       exp_short;
        logic       exp_long;
        logic       exp_dbl;
        logic [7:0] exp_cnt;
    } vec_t;

    vec_t vecs[27];

    // Drive inputs for one cycle and leave time at #1 after the edge for sampling.
    task automatic apply_stimulus(input logic st, input logic dn, input logic up, input logic rs);
        pb_state = st;
        pb_down  = dn;
        pb_up    = up;
        rst      = rs;
        @(posedge clk);
        #1;
    endtask

    task automatic check_output(input string name, input logic s, input logic l, input logic d,
                                input logic r, input logic [7:0] c);
        logic [11:0] act, exp;
        act = {short_press, long_press, double_click, repeat_tick, event_cnt};
        exp = {s, l, d, r, c};
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got s/l/d/r=%b%b%b%b cnt=%0d, want s/l/d/r=%b%b%b%b cnt=%0d",
                     name, act[11], act[10], act[9], act[8], act[7:0], s, l, d, r, c);
        end
    endtask

    // One short press: down, held one cycle, up, then short expected on the 5th idle edge.
    task automatic short_cycle(input logic [7:0] exp_cnt);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        for (int k = 1; k <= 4; k++) apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_output("wrap_short", 1'b1, 1'b0, 1'b0, 1'b0, exp_cnt);
    endtask

    initial begin
        logic [7:0] base;

        // Reset, held-through-reset ignore, short press, then double click.
        vecs[0]  = '{1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[1]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[2]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[3]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[4]  = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[5]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[6]  = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[7]  = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[8]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[9]  = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[10] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[11] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd0};
        vecs[12] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 8'd1};
        vecs[13] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[14] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[15] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[16] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[17] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[18] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[19] = '{1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[20] = '{1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd1};
        vecs[21] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 8'd2};
        vecs[22] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
        vecs[23] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
        vecs[24] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
        vecs[25] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};
        vecs[26] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 8'd2};

        for (int i = 0; i < 27; i++) begin
            apply_stimulus(vecs[i].st, vecs[i].dn, vecs[i].up, vecs[i].rs);
            check_output($sformatf("vec%0d", i), vecs[i].exp_short, vecs[i].exp_long,
                         vecs[i].exp_dbl, 1'b0, vecs[i].exp_cnt);
        end

        // Long press held 20 cycles: long at edge 10, repeat ticks at 14 and 18.
        base = 8'd2;
        for (int k = 0; k < 28; k++) begin
            logic exp_rep;
            exp_rep = REP_EN && (k == 14 || k == 18);
            if (k == 0)       apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
            else if (k < 20)  apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
            else if (k == 20) apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
            else              apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
            check_output($sformatf("long_k%0d", k), 1'b0, k == 10, 1'b0, exp_rep,
                         (k >= 10) ? base + 8'd1 : base);
        end

        // Reset while waiting for a second press discards the pending short.
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b1);
        check_output("rst_wait2", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
            check_output($sformatf("post_rst%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        end
        short_cycle(8'd1);

        // 256 short presses from reset wrap the counter back to zero.
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b1);
        check_output("rst_wrap", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int i = 1; i <= 256; i++) short_cycle(8'(i));
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        check_output("wrap_zero", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);

        // Simultaneous down+up in IDLE must not start a sequence.
        apply_stimulus(1'b0, 1'b1, 1'b1, 1'b0);
        check_output("both_edge", 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        for (int k = 0; k < 8; k++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
            check_output($sformatf("both_idle%0d", k), 1'b0, 1'b0, 1'b0, 1'b0, 8'd0);
        end

        // Level falling without pb_up acts as release; short 5 edges later.
        apply_stimulus(1'b1, 1'b1, 1'b0, 1'b0);
        apply_stimulus(1'b1, 1'b0, 1'b0, 1'b0);
        apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
        for (int k = 1; k <= 5; k++) begin
            apply_stimulus(1'b0, 1'b0, 1'b0, 1'b0);
            check_output($sformatf("lvl_rel%0d", k), k == 5, 1'b0, 1'b0, 1'b0,
                         (k == 5) ? 8'd1 : 8'd0);
        end
        apply_stimulus(1'b0, 1'b0, 1'b1, 1'b0);
        check_output("late_up", 1'b0, 1'b0, 1'b0, 1'b0, 8'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
